// File: rtl/eth_rx_aes_unpacker.sv
// Receive-side AES Ethernet unpacker: parses the padded MAC header and IP header of the
// TSE Avalon-ST stream and keeps only IPv4 frames addressed to the local MAC. Their
// payload is packed big-endian into AES-width blocks, and the dropped frames are counted.
module eth_rx_aes_unpacker #(
    parameter int unsigned STREAM_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH  = 128,
    parameter int unsigned IP_HDR_WORDS = 5,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [47:0]             cfg_mac_addr,
    input  logic [STREAM_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [1:0]              in_empty,
    output logic [BLOCK_WIDTH-1:0]  out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sop,
    output logic                    out_last,
    output logic [3:0]              out_empty,
    output logic [CNT_WIDTH-1:0]    frames_ok,
    output logic [CNT_WIDTH-1:0]    frames_dropped
);

    typedef enum logic [2:0] {StIdle, StMacHdr, StIpHdr, StPayload, StDrop} state_e;

    localparam int          Words         = int'(BLOCK_WIDTH / STREAM_WIDTH);
    localparam logic [15:0] EtherTypeIpv4 = 16'h0800;
    localparam logic [7:0]  IpLastCnt     = 8'(IP_HDR_WORDS - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    match_q, match_d;
    logic [1:0]              idx_q, idx_d;
    logic                    first_q, first_d;
    logic [BLOCK_WIDTH-1:0]  asm_q, asm_d;
    logic [BLOCK_WIDTH-1:0]  out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sop_q, out_sop_d;
    logic                    out_last_q, out_last_d;
    logic [3:0]              out_empty_q, out_empty_d;
    logic [CNT_WIDTH-1:0]    ok_q, drop_q;

    logic                    accept, out_free, load, last_blk, ok_evt, drop_evt;
    logic [STREAM_WIDTH-1:0] keep_mask;
    logic [BLOCK_WIDTH-1:0]  blk;

    // The output register can take a new block when empty or being drained this cycle.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !((state_q == StPayload) && !out_free);
    assign accept   = in_valid && in_ready;

    // Block as it would leave the assembler this cycle: earlier words, the current word
    // (trailing bytes cleared on eop), and zeros in the unfilled slots.
    always_comb begin
        keep_mask = {STREAM_WIDTH{1'b1}} << {in_empty, 3'b000};
        blk       = '0;
        asm_d     = asm_q;
        for (int k = 0; k < Words; k++) begin
            if (k < int'(idx_q)) begin
                blk[BLOCK_WIDTH-1-STREAM_WIDTH*k -: STREAM_WIDTH] =
                    asm_q[BLOCK_WIDTH-1-STREAM_WIDTH*k -: STREAM_WIDTH];
            end else if (k == int'(idx_q)) begin
                blk[BLOCK_WIDTH-1-STREAM_WIDTH*k -: STREAM_WIDTH] =
                    in_eop ? (in_data & keep_mask) : in_data;
                if (accept && state_q == StPayload && !in_sop) begin
                    asm_d[BLOCK_WIDTH-1-STREAM_WIDTH*k -: STREAM_WIDTH] = in_data;
                end
            end
        end
    end

    // Frame parser next-state logic and per-frame events.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        idx_d    = idx_q;
        first_d  = first_q;
        load     = 1'b0;
        last_blk = 1'b0;
        ok_evt   = 1'b0;
        drop_evt = 1'b0;
        if (accept) begin
            if (in_sop) begin
                // A new sop always starts over, aborting whatever frame was in progress.
                if (state_q != StIdle) drop_evt = 1'b1;
                match_d = (in_data[15:0] == cfg_mac_addr[47:32]);
                cnt_d   = 8'd1;
                if (in_eop) begin
                    drop_evt = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d  = StMacHdr;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                    end
                    StMacHdr: begin
                        if (in_eop) begin
                            drop_evt = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_q == 8'd1) begin
                                match_d = match_q && (in_data == cfg_mac_addr[31:0]);
                            end
                            if (cnt_q == 8'd3) begin
                                match_d = match_q && (in_data[15:0] == EtherTypeIpv4);
                                cnt_d   = 8'd0;
                                state_d = match_d ? StIpHdr : StDrop;
                            end
                        end
                    end
                    StIpHdr: begin
                        if (in_eop) begin
                            drop_evt = 1'b1;
                            state_d  = StIdle;
                        end else if (cnt_q == IpLastCnt) begin
                            state_d = StPayload;
                            idx_d   = 2'd0;
                            first_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    StPayload: begin
                        load  = (idx_q == 2'd3) || in_eop;
                        idx_d = idx_q + 2'd1;
                        if (in_eop) begin
                            last_blk = 1'b1;
                            ok_evt   = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    StDrop: begin
                        if (in_eop) begin
                            drop_evt = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
        if (load) first_d = 1'b0;
    end

    // Output register: load a finished block, otherwise hold while stalled or go idle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_last_d  = out_last_q;
        out_empty_d = out_empty_q;
        if (load) begin
            out_data_d  = blk;
            out_valid_d = 1'b1;
            out_sop_d   = first_q;
            out_last_d  = last_blk;
            out_empty_d = last_blk ? {2'd3 - idx_q, in_empty} : 4'd0;
        end else if (out_free) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_last_d  = 1'b0;
            out_empty_d = 4'd0;
        end
    end

    // State, assembly, output and saturating statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            match_q     <= 1'b0;
            idx_q       <= 2'd0;
            first_q     <= 1'b0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_empty_q <= 4'd0;
            ok_q        <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_last_q  <= out_last_d;
            out_empty_q <= out_empty_d;
            if (ok_evt && ok_q != '1) ok_q <= ok_q + CNT_WIDTH'(1);
            if (drop_evt && drop_q != '1) drop_q <= drop_q + CNT_WIDTH'(1);
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_sop        = out_sop_q;
    assign out_last       = out_last_q;
    assign out_empty      = out_empty_q;
    assign frames_ok      = ok_q;
    assign frames_dropped = drop_q;

endmodule

// File: tb/tb_eth_rx_aes_unpacker.sv
// Bench for eth_rx_aes_unpacker: directed scenarios plus randomized frames checked
// against a byte-level model of the filter and block packing.
module tb_eth_rx_aes_unpacker;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         last;
        logic [3:0]   empty;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [47:0]  cfg_mac_addr;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sop;
    logic         in_eop;
    logic [1:0]   in_empty;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_sop;
    logic         out_last;
    logic [3:0]   out_empty;
    logic [31:0]  frames_ok;
    logic [31:0]  frames_dropped;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           exp_ok   = 0;
    int           exp_drop = 0;
    int           out_mode = 0;  // 0: ready, 1: stalled, 2: random
    bit           gaps     = 0;
    blk_t         obs_q[$];
    blk_t         exp_q[$];
    logic [31:0]  frm[$];

    localparam logic [47:0] LocalMac = 48'h0011_2233_4455;
    localparam logic [47:0] SrcMac   = 48'hAABB_CCDD_EEFF;

    eth_rx_aes_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_mac_addr   (cfg_mac_addr),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_empty       (in_empty),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_last       (out_last),
        .out_empty      (out_empty),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Record every block accepted downstream.
    always @(negedge clk) begin
        if (out_valid && out_ready) obs_q.push_back({out_data, out_sop, out_last, out_empty});
    end

    // Reference: frame kept iff long enough to carry payload and addressed/typed right;
    // payload bytes are chopped into 16-byte big-endian blocks.
    function automatic void model_frame(input logic [31:0] w[$], input logic [1:0] emp,
                                        input logic [47:0] mac);
        logic [7:0] bytes[$];
        int         nblk;
        blk_t       e;
        if (w.size() < 10) begin
            exp_drop++;
            return;
        end
        if ({w[0][15:0], w[1]} != mac || w[3][15:0] != 16'h0800) begin
            exp_drop++;
            return;
        end
        for (int i = 9; i < w.size(); i++)
            for (int b = 0; b < 4; b++) bytes.push_back(w[i][31-8*b -: 8]);
        for (int i = 0; i < int'(emp); i++) void'(bytes.pop_back());
        nblk = (bytes.size() + 15) / 16;
        for (int k = 0; k < nblk; k++) begin
            e.data = '0;
            for (int j = 0; j < 16; j++)
                if (16 * k + j < bytes.size()) e.data[127-8*j -: 8] = bytes[16*k+j];
            e.sop   = (k == 0);
            e.last  = (k == nblk - 1);
            e.empty = e.last ? 4'(16 * nblk - bytes.size()) : 4'd0;
            exp_q.push_back(e);
        end
        exp_ok++;
    endfunction

    function automatic void build_hdr(input logic [47:0] dst, input logic [15:0] et);
        frm.delete();
        frm.push_back({16'h0, dst[47:32]});
        frm.push_back(dst[31:0]);
        frm.push_back(SrcMac[47:16]);
        frm.push_back({SrcMac[15:0], et});
        for (int i = 0; i < 5; i++) frm.push_back($urandom);
    endfunction

    task automatic drive_word(input logic [31:0] d, input bit sop, input bit eop,
                              input logic [1:0] emp);
        bit took = 0;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !took; n++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = 2'd0;
        n_checks++;
        if (!took) begin
            n_fail++;
            $display("FAIL in_ready_timeout: word %h not accepted, in_ready=%b required 1",
                     d, in_ready);
        end
    endtask

    task automatic send_frame(input logic [1:0] emp, input bit with_eop);
        bit last;
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            last = with_eop && (i == frm.size() - 1);
            drive_word(frm[i], i == 0, last, last ? emp : 2'd0);
        end
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        ok = (obs_q.size() >= exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sop, out_last, out_empty} !== 7'd0 || out_data !== '0
            || in_ready !== 1'b1 || frames_ok !== 32'd0 || frames_dropped !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b sop=%b last=%b empty=%0d data=%h rdy=%b ok=%0d drop=%0d required all 0 and rdy=1",
                     out_valid, out_sop, out_last, out_empty, out_data, in_ready, frames_ok,
                     frames_dropped);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        build_hdr(LocalMac, 16'h0800);
        for (int i = 1; i <= 8; i++) frm.push_back(32'(i));
        exp_q.push_back({128'h0000_0001_0000_0002_0000_0003_0000_0004, 1'b1, 1'b0, 4'd0});
        exp_q.push_back({128'h0000_0005_0000_0006_0000_0007_0000_0008, 1'b0, 1'b1, 4'd0});
        exp_ok++;
        send_frame(2'd0, 1'b1);
        build_hdr(LocalMac, 16'h0800);
        for (int i = 1; i <= 4; i++) frm.push_back(32'(i));
        frm.push_back(32'h0000_0009);
        exp_q.push_back({128'h0000_0001_0000_0002_0000_0003_0000_0004, 1'b1, 1'b0, 4'd0});
        exp_q.push_back({128'h0, 1'b0, 1'b1, 4'd14});
        exp_ok++;
        send_frame(2'd2, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d blocks required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_blk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frames_ok !== 32'(exp_ok) || frames_dropped !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL basic_counters: got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     frames_ok, frames_dropped, exp_ok, exp_drop);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_filter_drop();
        bit ok;
        build_hdr(48'h0011_2233_4456, 16'h0800);
        for (int i = 0; i < 4; i++) frm.push_back($urandom);
        model_frame(frm, 2'd0, cfg_mac_addr);
        send_frame(2'd0, 1'b1);
        build_hdr(LocalMac, 16'h86DD);
        for (int i = 0; i < 6; i++) frm.push_back($urandom);
        model_frame(frm, 2'd1, cfg_mac_addr);
        send_frame(2'd1, 1'b1);
        build_hdr(LocalMac, 16'h0800);
        for (int i = 0; i < 7; i++) frm.push_back($urandom);
        model_frame(frm, 2'd3, cfg_mac_addr);
        send_frame(2'd3, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL drop_count: got %0d blocks required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drop_blk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frames_ok !== 32'(exp_ok) || frames_dropped !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL drop_counters: got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     frames_ok, frames_dropped, exp_ok, exp_drop);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit           ok;
        bit           seen = 0;
        bit           stable = 1;
        logic [127:0] d0;
        build_hdr(LocalMac, 16'h0800);
        for (int i = 0; i < 8; i++) frm.push_back($urandom);
        model_frame(frm, 2'd0, cfg_mac_addr);
        out_mode = 1;
        fork
            send_frame(2'd0, 1'b1);
            begin
                for (int n = 0; n < 200 && !seen; n++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                d0 = out_data;
                repeat (10) begin
                    @(negedge clk);
                    if (out_data !== d0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
                end
                n_checks++;
                if (!seen || !stable) begin
                    n_fail++;
                    $display("FAIL stall_hold: seen=%b stable=%b in_ready=%b required seen=1 stable=1 in_ready=0",
                             seen, stable, in_ready);
                end
                out_mode = 0;
            end
        join
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: got %0d blocks required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_blk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_abort();
        bit ok;
        build_hdr(LocalMac, 16'h0800);
        frm.push_back(32'hA1A1_0001);
        send_frame(2'd0, 1'b0);
        exp_drop++;
        build_hdr(LocalMac, 16'h0800);
        for (int i = 0; i < 6; i++) frm.push_back($urandom);
        model_frame(frm, 2'd1, cfg_mac_addr);
        send_frame(2'd1, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_count: got %0d blocks required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_blk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frames_ok !== 32'(exp_ok) || frames_dropped !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL abort_counters: got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     frames_ok, frames_dropped, exp_ok, exp_drop);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_runt();
        bit ok;
        build_hdr(LocalMac, 16'h0800);
        while (frm.size() > 7) void'(frm.pop_back());
        model_frame(frm, 2'd0, cfg_mac_addr);
        send_frame(2'd0, 1'b1);
        build_hdr(LocalMac, 16'h0800);
        model_frame(frm, 2'd0, cfg_mac_addr);
        send_frame(2'd0, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL runt_output: got %0d blocks required 0", obs_q.size());
        end
        n_checks++;
        if (frames_ok !== 32'(exp_ok) || frames_dropped !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL runt_counters: got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     frames_ok, frames_dropped, exp_ok, exp_drop);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        out_mode = 1;
        build_hdr(LocalMac, 16'h0800);
        for (int i = 0; i < 4; i++) frm.push_back($urandom);
        send_frame(2'd0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pending: out_valid=%b required 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sop, out_last, out_empty} !== 7'd0 || out_data !== '0
            || in_ready !== 1'b1 || frames_ok !== 32'd0 || frames_dropped !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_state: valid=%b data=%h rdy=%b ok=%0d drop=%0d required all 0 and rdy=1",
                     out_valid, out_data, in_ready, frames_ok, frames_dropped);
        end
        rst = 1'b0;
        out_mode = 0;
        exp_ok = 0;
        exp_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit          ok;
        int          kind;
        int          npay;
        logic [47:0] dst;
        logic [15:0] et;
        logic [1:0]  emp;
        out_mode = 2;
        gaps = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            dst  = LocalMac;
            et   = 16'h0800;
            npay = $urandom_range(1, 10);
            emp  = 2'($urandom_range(0, 3));
            if (kind == 0) dst = dst ^ (48'd1 << $urandom_range(0, 47));
            if (kind == 1) et = 16'h86DD;
            if (kind == 3) drive_word($urandom, 1'b0, 1'($urandom_range(0, 1)), 2'd0);
            build_hdr(dst, et);
            for (int i = 0; i < npay; i++) frm.push_back($urandom);
            if (kind == 2) begin
                npay = $urandom_range(1, 9);
                while (frm.size() > npay) void'(frm.pop_back());
            end
            model_frame(frm, emp, cfg_mac_addr);
            send_frame(emp, 1'b1);
        end
        out_mode = 0;
        gaps = 0;
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d blocks required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_blk%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frames_ok !== 32'(exp_ok) || frames_dropped !== 32'(exp_drop)) begin
            n_fail++;
            $display("FAIL random_counters: got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     frames_ok, frames_dropped, exp_ok, exp_drop);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_mac_addr = LocalMac;
        in_data  = '0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = 2'd0;
        rst      = 1'b1;
        test_reset();
        test_basic();
        test_filter_drop();
        test_backpressure();
        test_abort();
        test_runt();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_aes_unpacker.md
Name: eth_rx_aes_unpacker

Overview:
- Receive-side counterpart of the AES Ethernet transmit path. Accepts the 32-bit Avalon-ST frame stream from the TSE MAC core and parses the 16-byte padded MAC header and the 20-byte IP header.
- Frames addressed to the local MAC with EtherType 0x0800 are kept. Their payload is packed big-endian into 128-bit blocks for the AES core.
- Frames that fail the checks are dropped and counted.

Parameters:
- STREAM_WIDTH, 32, input word width; fixed by the TSE core, must not change.
- BLOCK_WIDTH, 128, output block width (AES data width).
- IP_HDR_WORDS, 5, IP header length in words (160 bits).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_mac_addr  in  48  local MAC address, from the peripheral register block
- in_data  in  32  Avalon-ST data; first byte on wire in [31:24]
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_sop  in  1  first word of frame
- in_eop  in  1  last word of frame
- in_empty  in  2  invalid trailing bytes in the eop word
- out_data  out  128  payload block; first word in [127:96]
- out_valid  out  1  block valid
- out_ready  in  1  downstream accepts
- out_sop  out  1  first block of frame
- out_last  out  1  final block of frame
- out_empty  out  4  invalid trailing bytes of the last block (0-15); 0 when out_last=0
- frames_ok  out  CNT_WIDTH  frames forwarded (saturating)
- frames_dropped  out  CNT_WIDTH  frames discarded (saturating)

Behaviour:
- Reset: state IDLE. out_valid, out_sop, out_last, out_empty, out_data = 0. Both counters = 0. Assembly register cleared. in_ready = 1.
- Frame layout (MAC part is 4 words):
  - W0 = {16'h0 pad, dst[47:32]}
  - W1 = dst[31:0]
  - W2 = src[47:16]
  - W3 = {src[15:0], ethertype}
  - W4-W8 = IP header; the block ignores the IP header contents.
  - W9 onward = payload.
- States: IDLE, MAC_HDR, IP_HDR, PAYLOAD, DROP. Word counter is 8 bits.
- IDLE: words without in_sop are ignored. On a handshaked word with in_sop, compare W0[15:0] to cfg_mac_addr[47:32] and go to MAC_HDR.
- MAC_HDR:
  - W1 is compared to cfg_mac_addr[31:0].
  - W3[15:0] is compared to 16'h0800.
  - The match flag is the AND of all address and type comparisons.
  - After W3: go to IP_HDR if matched; otherwise go to DROP.
- IP_HDR: consume 5 words, then go to PAYLOAD.
- DROP: consume words until in_eop, increment frames_dropped, then go to IDLE.
- in_eop seen in MAC_HDR or IP_HDR (runt frame): frames_dropped += 1, go to IDLE, no output.
- PAYLOAD packing:
  - A 2-bit index places word k of each group into out_data[127-32k -: 32].
  - On the 4th word or on in_eop, the assembled block loads the output register. out_valid rises the next cycle (1-cycle latency).
  - out_sop = 1 on the first block of the frame.
- Frame end in PAYLOAD:
  - Bytes marked by in_empty are zeroed, as are all unfilled words.
  - out_last = 1 on that block.
  - out_empty = 4*(3 - idx) + in_empty.
  - frames_ok += 1; return to IDLE.
- in_eop on the first payload-less cycle (frame exactly 9 words): frames_dropped += 1, no output.
- Backpressure:
  - Output register holds out_data, out_valid and the flags stable while out_valid && !out_ready.
  - in_ready = 0 only in PAYLOAD while out_valid && !out_ready. It is 1 in all other states and cycles.
  - A block moves from the output register to downstream in the same cycle a new block loads it, without a bubble.
- in_sop while not in IDLE:
  - The current frame is aborted: the partial block is discarded, no out_last is sent, and frames_dropped += 1.
  - The word is processed as W0 of a new frame.
  - Blocks already in the output register are still delivered.
- Counters saturate at all-ones. If frames_ok and frames_dropped events coincide with another event in the same cycle, each counter increments at most once.
- rst mid-frame returns to the reset state immediately. The pending output block is lost.
- cfg_mac_addr is sampled at comparison time; a change mid-frame affects only later comparisons.

Test Plan:
- cfg_mac_addr=48'h0011_2233_4455; frame of W0=0000_0011, W1=2233_4455, W3={src,0800}, 5 IP words, payload 0x00000001..0x00000008, in_eop on the last word with empty=0 -> two blocks: 0000_0001_..._0000_0004 (sop=1), then ..._0005..._0008 (last=1, out_empty=0); frames_ok=1.
- Same frame with 5 payload words, last word empty=2 -> 2nd block = {0000_0009 & FFFF_0000, 96'h0}, out_last=1, out_empty=14.
- Dest W1=2233_4456 or ethertype 0x86DD -> no output, frames_dropped=1, following valid frame forwarded normally.
- out_ready held 0 for 10 cycles during payload -> in_ready=0 while first block is pending, out_data stable, no words lost; releasing out_ready gives back-to-back blocks.
- in_sop asserted at the 2nd payload word of frame A, followed by valid frame B -> A partial discarded, frames_dropped=1, B blocks correct with out_sop=1.
- Runt: in_eop on W6 -> no output, frames_dropped=1; rst asserted mid-payload -> all outputs 0 next cycle, counters 0.
